// File: rtl/problem1.sv
// Three-input truth-table evaluator (default: majority) with a registered copy of
// the output and a saturating rising-edge counter. Optional macro: PROBLEM1_SYNC_EN.
module problem1 #(
  parameter logic [7:0] TT    = 8'b1110_1000,
  parameter int         CNT_W = 8
) (
  output logic             X,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             clk,
  input  logic             rst_n,
  output logic             x_q,
  output logic [CNT_W-1:0] rise_cnt,
  input  logic             cnt_clr
);

  logic x_d;
  logic rise;

  // An unknown index yields X, so unknown inputs are never masked to 0.
  assign X = TT[{A, B, C}];

`ifdef PROBLEM1_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source and the two stages stay distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {A, B, C};
      sync2 <= sync1;
    end
  end

  assign x_d = TT[sync2];
`else
  assign x_d = X;
`endif

  // x_q itself holds the previous registered value, so a rise is "new 1, old 0".
  assign rise = x_d & ~x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= 1'b0;
      rise_cnt <= '0;
    end else begin
      x_q <= x_d;
      if (cnt_clr) begin
        rise_cnt <= '0;
      end else if (rise && (rise_cnt != {CNT_W{1'b1}})) begin
        rise_cnt <= rise_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_problem1.sv
// Self-checking bench for problem1: directed steps followed by random stimulus
// compared against a queue-based delay model of x_q and a rise counter.
module tb_problem1;

`ifdef PROBLEM1_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       x_maj, xq_maj;
  logic [7:0] cnt_maj;
  logic       x_sat, xq_sat;
  logic [1:0] cnt_sat;
  logic       x_par, xq_par;
  logic [7:0] cnt_par;

  int tests = 0;
  int fails = 0;

  problem1 u_maj (
    .X(x_maj), .A(A), .B(B), .C(C), .clk(clk), .rst_n(rst_n),
    .x_q(xq_maj), .rise_cnt(cnt_maj), .cnt_clr(cnt_clr)
  );

  problem1 #(.CNT_W(2)) u_sat (
    .X(x_sat), .A(A), .B(B), .C(C), .clk(clk), .rst_n(rst_n),
    .x_q(xq_sat), .rise_cnt(cnt_sat), .cnt_clr(cnt_clr)
  );

  problem1 #(.TT(8'b1001_0110)) u_par (
    .X(x_par), .A(A), .B(B), .C(C), .clk(clk), .rst_n(rst_n),
    .x_q(xq_par), .rise_cnt(cnt_par), .cnt_clr(cnt_clr)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic maj(input logic [2:0] abc);
    return $countones(abc) >= 2;
  endfunction

  // Reference: x_q is the majority value seen LAT edges ago (0 before that);
  // counters count 0->1 steps of that delayed stream, clamped, clear dominant.
  logic        hist[$];
  logic        m_xq = 1'b0;
  int unsigned m_cnt8 = 0;
  int unsigned m_cnt2 = 0;

  initial begin
    logic nx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        m_xq   = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else begin
        hist.push_front(maj({A, B, C}));
        nx = (hist.size() >= LAT) ? hist[LAT-1] : 1'b0;
        if (hist.size() > LAT) void'(hist.pop_back());
        if (cnt_clr) begin
          m_cnt8 = 0;
          m_cnt2 = 0;
        end else if (nx && !m_xq) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3)   m_cnt2++;
        end
        m_xq = nx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic drive(input logic [2:0] abc);
    {A, B, C} = abc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"},    32'(x_maj),   32'(maj({A, B, C})));
    check({tag, "_par"},  32'(x_par),   32'(^{A, B, C}));
    check({tag, "_xq"},   32'(xq_maj),  32'(m_xq));
    check({tag, "_cnt"},  32'(cnt_maj), m_cnt8);
    check({tag, "_sat"},  32'(cnt_sat), m_cnt2);
  endtask

  localparam logic [7:0] MAJ_TABLE = 8'b1110_1000;

  initial begin
    logic [2:0] abc;

    // Clock and reset idle: combinational sweep.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      drive(abc);
      #5;
      check($sformatf("sweep_x_%0d", i), 32'(x_maj), 32'(MAJ_TABLE[i]));
      check($sformatf("sweep_par_%0d", i), 32'(x_par), 32'(^abc));
    end
    check("reset_xq",  32'(xq_maj),  32'd0);
    check("reset_cnt", 32'(cnt_maj), 32'd0);

    // Run with 111, then assert reset between edges.
    rst_n  = 1'b1;
    drive(3'b111);
    clk_en = 1'b1;
    hold(LAT + 1);
    check("pre_rst_xq", 32'(xq_maj), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_xq",  32'(xq_maj),  32'd0);
    check("async_rst_cnt", 32'(cnt_maj), 32'd0);
    check("async_rst_x",   32'(x_maj),   32'd1);

    // Release reset, first rise, then a second rise via 000 -> 011.
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b110);
    repeat (LAT) @(posedge clk);
    #1;
    check("rise1_xq",  32'(xq_maj),  32'd1);
    check("rise1_cnt", 32'(cnt_maj), 32'd1);
    @(negedge clk);
    drive(3'b000);
    hold(LAT + 1);
    drive(3'b011);
    hold(LAT + 1);
    check("rise2_cnt", 32'(cnt_maj), 32'd2);

    // Five more rises: 2-bit counter pins at 3, 8-bit counter reaches 7.
    for (int i = 0; i < 5; i++) begin
      drive(3'b000);
      hold(LAT + 1);
      drive(3'b111);
      hold(LAT + 1);
    end
    check("sat_cnt2", 32'(cnt_sat), 32'd3);
    check("sat_cnt8", 32'(cnt_maj), 32'd7);

    // Clear on the same edge as a rise.
    drive(3'b000);
    hold(LAT + 1);
    drive(3'b111);
    hold(LAT - 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_win_xq",  32'(xq_maj),  32'd1);
    check("clr_win_cnt", 32'(cnt_maj), 32'd0);
    check("clr_win_sat", 32'(cnt_sat), 32'd0);

    // Parity table spot checks.
    drive(3'b111);
    #1;
    check("par_111", 32'(x_par), 32'd1);
    drive(3'b011);
    #1;
    check("par_011", 32'(x_par), 32'd0);
    @(negedge clk);

    // Random phase against the reference model.
    for (int i = 0; i < 300; i++) begin
      check_model($sformatf("rnd%0d", i));
      drive(3'($urandom_range(0, 7)));
      cnt_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("rnd%0d_rst_xq", i),  32'(xq_maj),  32'd0);
        check($sformatf("rnd%0d_rst_cnt", i), 32'(cnt_maj), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
